alu_arbiter: RTL and testbench

- Shares the single 8-bit ALU (ops: forward, add, and, or) between two requesters, e.g. the instruction-execute path and a future address/branch unit.
- Accepts requests through a REQ/GNT handshake and arbitrates round-robin.
- Drives the ALU's DATA1/DATA2/SELECT inputs from registers, waits out the ALU settle time, then returns a tagged, registered response.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM state encoding and the
// opcode-to-settle-time mapping.
package alu_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Add needs the longer carry-chain settle time; every other valid op uses the short one.
  function automatic int unsigned op_wait(input logic [2:0] op,
                                          input int unsigned add_wait,
                                          input int unsigned logic_wait);
    return (op == OP_ADD) ? add_wait : logic_wait;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: on a tie the requester not served last wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio;  // requester index preferred on the next tie

  assign grant = (req == 2'b11) ? (prio ? 2'b10 : 2'b01) : req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 8-bit ALU between two requesters: round-robin grant,
// registered ALU operands, fixed settle wait, then a tagged one-cycle response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADD_WAIT   = 2,
  parameter int unsigned LOGIC_WAIT = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ0,
  input  logic [2:0]       OP0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  output logic             GNT0,
  input  logic             REQ1,
  input  logic [2:0]       OP1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             GNT1,
  output logic [WIDTH-1:0] ALU_DATA1,
  output logic [WIDTH-1:0] ALU_DATA2,
  output logic [2:0]       ALU_SELECT,
  input  logic [WIDTH-1:0] ALU_RESULT,
  output logic             RESP_VALID,
  output logic             RESP_ID,
  output logic             RESP_ERR,
  output logic [WIDTH-1:0] RESP_DATA,
  output logic             BUSY
);

  localparam int unsigned MAX_WAIT = (ADD_WAIT > LOGIC_WAIT) ? ADD_WAIT : LOGIC_WAIT;
  localparam int unsigned CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  if (ADD_WAIT == 0 || LOGIC_WAIT == 0) begin : g_bad_wait
    $error("alu_arbiter: ADD_WAIT and LOGIC_WAIT must both be non-zero");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             advance;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  assign advance = (state == S_IDLE) && (REQ0 || REQ1);
  assign sel_op  = grant[1] ? OP1 : OP0;
  assign sel_a   = grant[1] ? A1  : A0;
  assign sel_b   = grant[1] ? B1  : B0;
  assign BUSY    = (state != S_IDLE);

  rr_arbiter2 u_arb (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .req     ({REQ1, REQ0}),
    .advance (advance),
    .grant   (grant)
  );

  // NOTE: every register here uses <= so all of them see pre-edge values of
  // each other; blocking = would make ordering inside the block matter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      cnt        <= '0;
      GNT0       <= 1'b0;
      GNT1       <= 1'b0;
      ALU_DATA1  <= '0;
      ALU_DATA2  <= '0;
      ALU_SELECT <= '0;
      RESP_VALID <= 1'b0;
      RESP_ID    <= 1'b0;
      RESP_ERR   <= 1'b0;
      RESP_DATA  <= '0;
    end else begin
      GNT0       <= 1'b0;
      GNT1       <= 1'b0;
      RESP_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          if (advance) begin
            GNT0    <= grant[0];
            GNT1    <= grant[1];
            RESP_ID <= grant[1];
            if (sel_op[2]) begin
              // Unsupported opcode: answer at once and leave the ALU untouched.
              state      <= S_RESP;
              RESP_VALID <= 1'b1;
              RESP_ERR   <= 1'b1;
              RESP_DATA  <= '0;
            end else begin
              state      <= S_EXEC;
              ALU_DATA1  <= sel_a;
              ALU_DATA2  <= sel_b;
              ALU_SELECT <= sel_op;
              cnt        <= CNT_W'(op_wait(sel_op, ADD_WAIT, LOGIC_WAIT));
            end
          end
        end
        S_EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= S_RESP;
            RESP_VALID <= 1'b1;
            RESP_ERR   <= 1'b0;
            RESP_DATA  <= ALU_RESULT;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, scoreboard of expected
// responses, per-scenario tasks for latency, arbitration and reset behaviour.
module tb_alu_arbiter;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             REQ0 = 1'b0, REQ1 = 1'b0;
  logic [2:0]       OP0 = '0, OP1 = '0;
  logic [WIDTH-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic             GNT0, GNT1;
  logic [WIDTH-1:0] ALU_DATA1, ALU_DATA2, ALU_RESULT, RESP_DATA;
  logic [2:0]       ALU_SELECT;
  logic             RESP_VALID, RESP_ID, RESP_ERR, BUSY;

  typedef struct packed {
    logic             id;
    logic             err;
    logic [WIDTH-1:0] data;
  } resp_t;

  resp_t sb[$];
  int    checks = 0;
  int    errors = 0;

  always #5 CLK = ~CLK;

  // Existing ALU: forward passes DATA2.
  always_comb begin
    case (ALU_SELECT)
      3'b000:  ALU_RESULT = ALU_DATA2;
      3'b001:  ALU_RESULT = ALU_DATA1 + ALU_DATA2;
      3'b010:  ALU_RESULT = ALU_DATA1 & ALU_DATA2;
      3'b011:  ALU_RESULT = ALU_DATA1 | ALU_DATA2;
      default: ALU_RESULT = '0;
    endcase
  end

  alu_arbiter #(.WIDTH(WIDTH), .ADD_WAIT(2), .LOGIC_WAIT(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .OP0(OP0), .A0(A0), .B0(B0), .GNT0(GNT0),
    .REQ1(REQ1), .OP1(OP1), .A1(A1), .B1(B1), .GNT1(GNT1),
    .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2), .ALU_SELECT(ALU_SELECT),
    .ALU_RESULT(ALU_RESULT),
    .RESP_VALID(RESP_VALID), .RESP_ID(RESP_ID), .RESP_ERR(RESP_ERR),
    .RESP_DATA(RESP_DATA), .BUSY(BUSY)
  );

  // Response scoreboard and grant-exclusivity monitor.
  always @(posedge CLK) begin
    resp_t exp_r;
    #1;
    if (GNT0 || GNT1) begin
      checks++;
      if (GNT0 && GNT1) begin
        errors++;
        $display("FAIL gnt_overlap got GNT0=%0b GNT1=%0b expected one-hot", GNT0, GNT1);
      end
    end
    if (RESP_VALID) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got id=%0d err=%0d data=%0d expected no response",
                 RESP_ID, RESP_ERR, RESP_DATA);
      end else begin
        exp_r = sb.pop_front();
        if ({RESP_ID, RESP_ERR, RESP_DATA} !== exp_r) begin
          errors++;
          $display("FAIL resp_content got id=%0d err=%0d data=%0d expected id=%0d err=%0d data=%0d",
                   RESP_ID, RESP_ERR, RESP_DATA, exp_r.id, exp_r.err, exp_r.data);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (BUSY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got BUSY=1 expected 0 within 20 cycles");
    end
  endtask

  // Single request from one requester; checks grant, grant width and latency.
  task automatic issue(input logic id, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_data,
                       input logic exp_err, input int exp_lat, input string name);
    int lat;
    wait_idle();
    sb.push_back({id, exp_err, exp_data});
    if (id) begin REQ1 = 1'b1; OP1 = op; A1 = a; B1 = b; end
    else    begin REQ0 = 1'b1; OP0 = op; A0 = a; B0 = b; end
    @(posedge CLK); #1;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    checks++;
    if ({GNT1, GNT0} !== (id ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL %s_grant got %b expected %b", name, {GNT1, GNT0}, id ? 2'b10 : 2'b01);
    end
    lat = 1;
    while (!RESP_VALID && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 2) begin
        checks++;
        if ({GNT1, GNT0} !== 2'b00) begin
          errors++;
          $display("FAIL %s_grant_pulse got %b expected 00", name, {GNT1, GNT0});
        end
      end
    end
    checks++;
    if (!RESP_VALID || lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d (valid=%0b) expected %0d", name, lat, RESP_VALID, exp_lat);
    end
  endtask

  // Both requesters raised together; each drops REQ on its grant. Expects 0 then 1.
  task automatic run_pair(input string name);
    int order[2];
    int ngnt = 0;
    int nresp = 0;
    int cyc = 0;
    while (nresp < 2 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (GNT0 || GNT1) begin
        if (ngnt < 2) order[ngnt] = GNT1 ? 1 : 0;
        ngnt++;
        if (GNT0) REQ0 = 1'b0;
        if (GNT1) REQ1 = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
          errors++;
          $display("FAIL %s_busy_at_grant got %0b expected 1", name, BUSY);
        end
      end
      if (RESP_VALID) begin
        nresp++;
        checks++;
        if (BUSY !== 1'b1) begin
          errors++;
          $display("FAIL %s_busy_at_resp got %0b expected 1", name, BUSY);
        end
      end
    end
    checks++;
    if (ngnt != 2 || nresp != 2 || order[0] != 0 || order[1] != 1) begin
      errors++;
      $display("FAIL %s_order got grants=%0d resps=%0d first=%0d second=%0d expected 2 2 0 1",
               name, ngnt, nresp, order[0], order[1]);
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({GNT0, GNT1, ALU_DATA1, ALU_DATA2, ALU_SELECT, RESP_VALID, RESP_ID, RESP_ERR,
         RESP_DATA, BUSY} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sel=%b d1=%0d d2=%0d data=%0d busy=%0b expected all 0",
               ALU_SELECT, ALU_DATA1, ALU_DATA2, RESP_DATA, BUSY);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_forward();
    issue(1'b0, 3'b000, 8'd5, 8'd25, 8'd25, 1'b0, 2, "fwd");
  endtask

  task automatic test_add();
    issue(1'b1, 3'b001, 8'd50, 8'd60, 8'd110, 1'b0, 3, "add");
    issue(1'b1, 3'b001, 8'd200, 8'd100, 8'd44, 1'b0, 3, "add_wrap");
  endtask

  task automatic test_both_from_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    REQ0 = 1'b1; OP0 = 3'b010; A0 = 8'd240; B0 = 8'd15;
    REQ1 = 1'b1; OP1 = 3'b011; A1 = 8'd63;  B1 = 8'd31;
    sb.push_back({1'b0, 1'b0, 8'd0});
    sb.push_back({1'b1, 1'b0, 8'd63});
    @(negedge CLK);
    RESET_N = 1'b1;
    run_pair("both");
  endtask

  task automatic test_back_to_back();
    int ngnt = 0;
    int cyc = 0;
    int who;
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    REQ0 = 1'b1; OP0 = 3'b001; A0 = 8'd7;   B0 = 8'd9;
    REQ1 = 1'b1; OP1 = 3'b011; A1 = 8'h50; B1 = 8'h05;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb.push_back({1'b0, 1'b0, 8'd16});
      else            sb.push_back({1'b1, 1'b0, 8'h55});
    end
    while (ngnt < 6 && cyc < 80) begin
      @(posedge CLK); #1;
      cyc++;
      if (GNT0 || GNT1) begin
        who = GNT1 ? 1 : 0;
        checks++;
        if (who != ngnt % 2) begin
          errors++;
          $display("FAIL b2b_grant%0d got requester %0d expected %0d", ngnt, who, ngnt % 2);
        end
        ngnt++;
      end
    end
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    checks++;
    if (ngnt != 6) begin
      errors++;
      $display("FAIL b2b_count got %0d grants expected 6", ngnt);
    end
    wait_idle();
  endtask

  task automatic test_error();
    logic [2:0]       sel_before;
    logic [WIDTH-1:0] d1_before;
    wait_idle();
    sel_before = ALU_SELECT;
    d1_before  = ALU_DATA1;
    issue(1'b0, 3'b101, 8'h12, 8'h34, 8'd0, 1'b1, 1, "err");
    checks++;
    if (ALU_SELECT !== sel_before || ALU_DATA1 !== d1_before) begin
      errors++;
      $display("FAIL err_alu_hold got sel=%b d1=%0d expected sel=%b d1=%0d",
               ALU_SELECT, ALU_DATA1, sel_before, d1_before);
    end
  endtask

  task automatic test_reset_mid_exec();
    wait_idle();
    REQ1 = 1'b1; OP1 = 3'b001; A1 = 8'd10; B1 = 8'd20;
    sb.push_back({1'b1, 1'b0, 8'd30});
    @(posedge CLK); #1;
    REQ1 = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy got %0b expected 1", BUSY);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({GNT0, GNT1, ALU_DATA1, ALU_DATA2, ALU_SELECT, RESP_VALID, RESP_ID, RESP_ERR,
         RESP_DATA, BUSY} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got sel=%b d1=%0d d2=%0d id=%0b busy=%0b expected all 0",
               ALU_SELECT, ALU_DATA1, ALU_DATA2, RESP_ID, BUSY);
    end
    sb.delete();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    REQ0 = 1'b1; OP0 = 3'b000; A0 = 8'd1; B0 = 8'd2;
    REQ1 = 1'b1; OP1 = 3'b010; A1 = 8'd3; B1 = 8'd6;
    sb.push_back({1'b0, 1'b0, 8'd2});
    sb.push_back({1'b1, 1'b0, 8'd2});
    RESET_N = 1'b1;
    run_pair("post_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_forward();
    test_add();
    test_error();
    test_both_from_reset();
    test_back_to_back();
    test_reset_mid_exec();
    wait_idle();
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
